// File: rtl/usr_lp0_buf.sv
// usr_lp0_buf: AXI-Stream loopback buffer between the H2C master stream and
// the C2H loopback select stage. Circular RAM plus one registered output
// stage (first-word-fall-through). Holds up to 2^DEPTH_LOG2 beats in total,
// output register included, and reports fill level and delivered beat/packet
// counts.
//
// Optional store-and-forward build: define USR_LP0_PKT_MODE_EN. The output
// stage then only pulls from the RAM while a complete packet is buffered,
// with a cut-through escape when a packet longer than the buffer fills it.

`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef KEEP_WIDTH
`define KEEP_WIDTH 8
`endif

module usr_lp0_buf #(
  parameter int DEPTH_LOG2 = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic [`DATA_WIDTH-1:0]  s_axis_tdata_i,
  input  logic [`KEEP_WIDTH-1:0]  s_axis_tkeep_i,
  input  logic [`KEEP_WIDTH-1:0]  s_axis_tuser_i,
  input  logic                    s_axis_tlast_i,
  input  logic                    s_axis_tvalid_i,
  output logic                    s_axis_tready_o,
  output logic [`DATA_WIDTH-1:0]  m_axis_tdata_o,
  output logic [`KEEP_WIDTH-1:0]  m_axis_tkeep_o,
  output logic [`KEEP_WIDTH-1:0]  m_axis_tuser_o,
  output logic                    m_axis_tlast_o,
  output logic                    m_axis_tvalid_o,
  input  logic                    m_axis_tready_i,
  output logic [DEPTH_LOG2:0]     level_o,
  output logic [CNT_WIDTH-1:0]    pkt_cnt_o,
  output logic [CNT_WIDTH-1:0]    beat_cnt_o
);

  localparam int DW    = `DATA_WIDTH;
  localparam int KW    = `KEEP_WIDTH;
  localparam int WW    = KW + 1 + KW + DW;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] LVL_FULL = PW'(DEPTH);

  // Storage word layout: {tuser, tlast, tkeep, tdata}
  logic [WW-1:0] ram [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] level;
  logic [PW-1:0] level_next;
  logic          tready_q;

  logic          out_valid;
  logic          out_last;
  logic [DW-1:0] out_data;
  logic [KW-1:0] out_keep;
  logic [KW-1:0] out_user;

  logic [CNT_WIDTH-1:0] pkt_cnt;
  logic [CNT_WIDTH-1:0] beat_cnt;

  logic          push;
  logic          pop;
  logic          can_load;
  logic          ram_empty;
  logic          load_ok;
  logic          bypass;
  logic          ram_rd;
  logic          ram_wr;
  logic          out_load;
  logic [WW-1:0] in_word;
  logic [WW-1:0] ram_word;
  logic [WW-1:0] load_word;

  // Ready is held low during flush and reset so a beat offered then is
  // never acknowledged, even if the registered ready was still high.
  assign s_axis_tready_o = tready_q & ~flush_i & ~rst_i;

  assign push      = s_axis_tvalid_i & s_axis_tready_o;
  assign pop       = out_valid & m_axis_tready_i;
  assign can_load  = ~out_valid | pop;
  assign ram_empty = (wr_ptr == rd_ptr);
  assign in_word   = {s_axis_tuser_i, s_axis_tlast_i, s_axis_tkeep_i, s_axis_tdata_i};
  assign ram_word  = ram[rd_ptr[DEPTH_LOG2-1:0]];

  // An empty RAM with a free output stage lets the incoming beat skip the
  // RAM entirely, giving the one-cycle minimum latency.
  assign bypass    = can_load & ram_empty & push & load_ok;
  assign ram_rd    = can_load & ~ram_empty & load_ok;
  assign ram_wr    = push & ~bypass;
  assign out_load  = bypass | ram_rd;
  assign load_word = bypass ? in_word : ram_word;

`ifdef USR_LP0_PKT_MODE_EN
  logic [PW-1:0] stored_pkts;
  logic [PW-1:0] stored_pkts_next;
  logic          escape;
  logic          push_last;
  logic          pop_last;

  assign push_last = push & s_axis_tlast_i;
  assign pop_last  = pop & out_last;

  // Packets still buffered after this cycle's traffic; gating on the
  // post-update count stops a partial packet from following a finished one.
  always_comb begin
    stored_pkts_next = stored_pkts + PW'(push_last) - PW'(pop_last);
  end

  assign load_ok = (stored_pkts_next != '0) | (escape & ~pop_last);

  // Complete-packet count and the oversize-packet escape flag.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      stored_pkts <= '0;
      escape      <= 1'b0;
    end else begin
      stored_pkts <= stored_pkts_next;
      if (pop_last) begin
        escape <= 1'b0;
      end else if (level == LVL_FULL && stored_pkts == '0) begin
        escape <= 1'b1;
      end
    end
  end
`else
  assign load_ok = 1'b1;
`endif

  // Total occupancy: RAM contents plus the output register.
  always_comb begin
    level_next = level + PW'(push) - PW'(pop);
  end

  // RAM write port; contents need no reset since pointers define validity.
  always_ff @(posedge clk_i) begin
    if (ram_wr) begin
      ram[wr_ptr[DEPTH_LOG2-1:0]] <= in_word;
    end
  end

  // Pointers, level and registered input ready.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      tready_q <= 1'b0;
    end else begin
      if (ram_wr) wr_ptr <= wr_ptr + PW'(1);
      if (ram_rd) rd_ptr <= rd_ptr + PW'(1);
      level    <= level_next;
      tready_q <= (level_next != LVL_FULL);
    end
  end

  // Output register: loads on a free slot, otherwise holds until taken.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_user  <= '0;
    end else if (flush_i) begin
      out_valid <= 1'b0;
    end else if (out_load) begin
      out_valid <= 1'b1;
      {out_user, out_last, out_keep, out_data} <= load_word;
    end else if (pop) begin
      out_valid <= 1'b0;
    end
  end

  // Delivered beat and packet counters; flush leaves them alone.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pkt_cnt  <= '0;
      beat_cnt <= '0;
    end else if (pop) begin
      beat_cnt <= beat_cnt + CNT_WIDTH'(1);
      if (out_last) pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
    end
  end

  assign m_axis_tvalid_o = out_valid;
  assign m_axis_tlast_o  = out_last;
  assign m_axis_tdata_o  = out_data;
  assign m_axis_tkeep_o  = out_keep;
  assign m_axis_tuser_o  = out_user;
  assign level_o         = level;
  assign pkt_cnt_o       = pkt_cnt;
  assign beat_cnt_o      = beat_cnt;

endmodule

// File: tb/tb_usr_lp0_buf.sv
// Directed bench for usr_lp0_buf (depth 16, 8-bit counters so wrap is cheap).

`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef KEEP_WIDTH
`define KEEP_WIDTH 8
`endif

module tb_usr_lp0_buf;
  localparam int DL = 4;
  localparam int CW = 8;
  localparam int DW = `DATA_WIDTH;
  localparam int KW = `KEEP_WIDTH;
  localparam int WW = KW + 1 + KW + DW;

  logic          clk = 1'b0;
  logic          rst, flush;
  logic [DW-1:0] s_data;
  logic [KW-1:0] s_keep, s_user;
  logic          s_last, s_valid, s_ready;
  logic [DW-1:0] m_data;
  logic [KW-1:0] m_keep, m_user;
  logic          m_last, m_valid, m_ready;
  logic [DL:0]   level;
  logic [CW-1:0] pkt_cnt, beat_cnt;

  int checks = 0;
  int errors = 0;
  logic [CW-1:0] exp_pkts = '0;
  logic [CW-1:0] exp_beats = '0;

  always #5 clk = ~clk;

  usr_lp0_buf #(.DEPTH_LOG2(DL), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .s_axis_tdata_i(s_data), .s_axis_tkeep_i(s_keep), .s_axis_tuser_i(s_user),
    .s_axis_tlast_i(s_last), .s_axis_tvalid_i(s_valid), .s_axis_tready_o(s_ready),
    .m_axis_tdata_o(m_data), .m_axis_tkeep_o(m_keep), .m_axis_tuser_o(m_user),
    .m_axis_tlast_o(m_last), .m_axis_tvalid_o(m_valid), .m_axis_tready_i(m_ready),
    .level_o(level), .pkt_cnt_o(pkt_cnt), .beat_cnt_o(beat_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; flush = 0; s_valid = 0; s_last = 0; m_ready = 0;
    s_data = '0; s_keep = '0; s_user = '0;
    tick(); tick();
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b expected 0", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", m_valid); end
    checks++; if ({m_user, m_last, m_keep, m_data} !== '0) begin errors++; $display("FAIL reset_payload: got %h expected 0", {m_user, m_last, m_keep, m_data}); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    checks++; if (pkt_cnt !== 8'd0 || beat_cnt !== 8'd0) begin errors++; $display("FAIL reset_counts: got pkt %0d beat %0d expected 0 0", pkt_cnt, beat_cnt); end
    rst = 0;
    #1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_release_tready: got %b expected 0", s_ready); end
    tick();
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_tready_rise: got %b expected 1", s_ready); end
  endtask

  task automatic test_single_beats();
    m_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      s_valid = 1; s_last = 1; s_data = 64'(i); s_keep = 8'(i); s_user = 8'(8'hA0 + i);
      tick();
      checks++;
      if (m_valid !== 1'b1 || m_data !== 64'(i) || m_last !== 1'b1 || m_keep !== 8'(i) || m_user !== 8'(8'hA0 + i)) begin
        errors++; $display("FAIL single_beat%0d: got v%b d%0h k%0h u%0h l%b expected v1 d%0h", i, m_valid, m_data, m_keep, m_user, m_last, i);
      end
      checks++; if (level !== 5'd1) begin errors++; $display("FAIL single_level%0d: got %0d expected 1", i, level); end
    end
    s_valid = 0; s_last = 0;
    tick();
    exp_pkts += 8; exp_beats += 8;
    checks++; if (m_valid !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL single_drain: got v%b level %0d expected v0 level 0", m_valid, level); end
    checks++; if (pkt_cnt !== 8'd8) begin errors++; $display("FAIL single_pkt_cnt: got %0d expected 8", pkt_cnt); end
    checks++; if (beat_cnt !== 8'd8) begin errors++; $display("FAIL single_beat_cnt: got %0d expected 8", beat_cnt); end
  endtask

  task automatic test_fill();
    int pushed;
    pushed = 0;
    m_ready = 0; s_last = 0; s_keep = 8'hFF; s_user = 8'h00;
    for (int c = 0; c < 24; c++) begin
      s_valid = 1; s_data = 64'(100 + pushed);
      #1;
      if (s_ready === 1'b1) pushed++;
      tick();
    end
    s_valid = 0;
    checks++; if (pushed !== 16) begin errors++; $display("FAIL fill_accepted: got %0d expected 16", pushed); end
    checks++; if (s_ready !== 1'b0 || level !== 5'd16) begin errors++; $display("FAIL fill_full: got tready %b level %0d expected 0 16", s_ready, level); end
    checks++; if (m_valid !== 1'b1 || m_data !== 64'd100) begin errors++; $display("FAIL fill_head: got v%b d%0d expected v1 d100", m_valid, m_data); end
    m_ready = 1;
    #1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL fill_tready_pop_cycle: got %b expected 0", s_ready); end
    for (int k = 0; k < 16; k++) begin
      checks++; if (m_valid !== 1'b1 || m_data !== 64'(100 + k)) begin errors++; $display("FAIL fill_out%0d: got v%b d%0d expected v1 d%0d", k, m_valid, m_data, 100 + k); end
      tick();
      if (k == 0) begin
        checks++; if (s_ready !== 1'b1 || level !== 5'd15) begin errors++; $display("FAIL fill_reassert: got tready %b level %0d expected 1 15", s_ready, level); end
      end
    end
    exp_beats += 16;
    checks++; if (m_valid !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL fill_empty: got v%b level %0d expected v0 level 0", m_valid, level); end
  endtask

  task automatic test_flush();
    m_ready = 0; s_last = 0; s_keep = 8'hFF; s_user = 8'h00;
    for (int k = 0; k < 5; k++) begin
      s_valid = 1; s_data = 64'(200 + k);
      tick();
    end
    s_valid = 0;
    checks++; if (level !== 5'd5 || m_valid !== 1'b1 || m_data !== 64'd200) begin errors++; $display("FAIL flush_pre: got level %0d v%b d%0d expected 5 v1 d200", level, m_valid, m_data); end
    flush = 1; s_valid = 1; s_data = 64'hDEAD;
    #1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL flush_no_ack: got tready %b expected 0", s_ready); end
    tick();
    checks++; if (m_valid !== 1'b0 || level !== 5'd0 || s_ready !== 1'b0) begin errors++; $display("FAIL flush_clear: got v%b level %0d tready %b expected v0 0 0", m_valid, level, s_ready); end
    checks++; if (pkt_cnt !== exp_pkts || beat_cnt !== exp_beats) begin errors++; $display("FAIL flush_counts: got pkt %0d beat %0d expected %0d %0d", pkt_cnt, beat_cnt, exp_pkts, exp_beats); end
    flush = 0; s_valid = 0;
    #1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL flush_drop_cycle: got tready %b expected 0", s_ready); end
    tick();
    checks++; if (s_ready !== 1'b1 || level !== 5'd0) begin errors++; $display("FAIL flush_tready_back: got tready %b level %0d expected 1 0", s_ready, level); end
    m_ready = 1; s_valid = 1; s_last = 1; s_data = 64'h55;
    tick();
    s_valid = 0; s_last = 0;
    checks++; if (m_valid !== 1'b1 || m_data !== 64'h55) begin errors++; $display("FAIL flush_next_beat: got v%b d%0h expected v1 d55", m_valid, m_data); end
    tick();
    exp_pkts += 1; exp_beats += 1;
    checks++; if (pkt_cnt !== exp_pkts || beat_cnt !== exp_beats) begin errors++; $display("FAIL flush_after_counts: got pkt %0d beat %0d expected %0d %0d", pkt_cnt, beat_cnt, exp_pkts, exp_beats); end
  endtask

  task automatic test_counter_wrap();
    int n;
    n = 255 - int'(exp_pkts);
    m_ready = 1; s_keep = 8'hFF; s_user = 8'h00;
    for (int i = 0; i < n; i++) begin
      s_valid = 1; s_last = 1; s_data = 64'(i);
      tick();
    end
    s_valid = 0;
    tick();
    exp_pkts += 8'(n); exp_beats += 8'(n);
    checks++; if (pkt_cnt !== 8'hFF) begin errors++; $display("FAIL wrap_all_ones: got %0h expected ff", pkt_cnt); end
    checks++; if (beat_cnt !== exp_beats) begin errors++; $display("FAIL wrap_beats: got %0h expected %0h", beat_cnt, exp_beats); end
    s_valid = 1; s_last = 1; s_data = 64'h77;
    tick();
    s_valid = 0; s_last = 0;
    tick();
    exp_pkts += 1; exp_beats += 1;
    checks++; if (pkt_cnt !== 8'h00) begin errors++; $display("FAIL wrap_zero: got %0h expected 00", pkt_cnt); end
    checks++; if (beat_cnt !== exp_beats) begin errors++; $display("FAIL wrap_beats_after: got %0h expected %0h", beat_cnt, exp_beats); end
  endtask

  task automatic test_reset_mid_packet();
    m_ready = 0; s_last = 0; s_keep = 8'hFF; s_user = 8'h00;
    for (int k = 0; k < 3; k++) begin
      s_valid = 1; s_data = 64'(500 + k);
      tick();
    end
    s_valid = 0; rst = 1;
    tick();
    exp_pkts = '0; exp_beats = '0;
    checks++; if (m_valid !== 1'b0 || level !== 5'd0 || s_ready !== 1'b0) begin errors++; $display("FAIL rstmid_clear: got v%b level %0d tready %b expected 0 0 0", m_valid, level, s_ready); end
    checks++; if (pkt_cnt !== 8'd0 || beat_cnt !== 8'd0) begin errors++; $display("FAIL rstmid_counts: got pkt %0d beat %0d expected 0 0", pkt_cnt, beat_cnt); end
    rst = 0;
    tick();
    m_ready = 1; s_valid = 1; s_last = 1; s_data = 64'h99;
    tick();
    s_valid = 0; s_last = 0;
    checks++; if (m_valid !== 1'b1 || m_data !== 64'h99 || m_last !== 1'b1) begin errors++; $display("FAIL rstmid_first: got v%b d%0h l%b expected v1 d99 l1", m_valid, m_data, m_last); end
    tick();
    exp_pkts = 8'd1; exp_beats = 8'd1;
    checks++; if (m_valid !== 1'b0 || level !== 5'd0 || pkt_cnt !== 8'd1) begin errors++; $display("FAIL rstmid_after: got v%b level %0d pkt %0d expected 0 0 1", m_valid, level, pkt_cnt); end
  endtask

  task automatic test_random();
    logic [WW-1:0] q[$];
    logic [WW-1:0] cur, prev_out, now_out;
    logic          cur_valid, prev_hold;
    int            sent, pkt_left, cyc;
    cur = '0; prev_out = '0; cur_valid = 0; prev_hold = 0;
    sent = 0; pkt_left = 0; cyc = 0;
    while ((sent < 1000 || pkt_left != 0 || q.size() != 0 || cur_valid) && cyc < 20000) begin
      now_out = {m_user, m_last, m_keep, m_data};
      if (prev_hold) begin
        checks++; if (m_valid !== 1'b1 || now_out !== prev_out) begin errors++; $display("FAIL rand_hold cyc %0d: got v%b %h expected v1 %h", cyc, m_valid, now_out, prev_out); end
      end
      checks++; if (level !== 5'(q.size())) begin errors++; $display("FAIL rand_level cyc %0d: got %0d expected %0d", cyc, level, q.size()); end
      if (!cur_valid && (sent < 1000 || pkt_left != 0) && $urandom_range(0, 1) == 1) begin
        if (pkt_left == 0) pkt_left = $urandom_range(1, 20);
        cur = {8'($urandom), (pkt_left == 1), 8'($urandom), $urandom, $urandom};
        cur_valid = 1; pkt_left--; sent++;
      end
      s_valid = cur_valid;
      {s_user, s_last, s_keep, s_data} = cur;
      m_ready = (sent >= 1000 && pkt_left == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      if (m_valid === 1'b1 && m_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand_extra cyc %0d: got %h expected no beat", cyc, now_out);
        end else begin
          if (now_out !== q[0]) begin errors++; $display("FAIL rand_data cyc %0d: got %h expected %h", cyc, now_out, q[0]); end
          void'(q.pop_front());
        end
        exp_beats += 1;
        if (m_last === 1'b1) exp_pkts += 1;
      end
      if (cur_valid && s_ready === 1'b1) begin
        q.push_back(cur);
        cur_valid = 0;
      end
      prev_hold = (m_valid === 1'b1) && !m_ready;
      prev_out = now_out;
      tick();
      cyc++;
    end
    s_valid = 0; s_last = 0;
    checks++; if (cyc >= 20000) begin errors++; $display("FAIL rand_timeout: got %0d cycles expected under 20000", cyc); end
    checks++; if (pkt_cnt !== exp_pkts || beat_cnt !== exp_beats) begin errors++; $display("FAIL rand_counts: got pkt %0d beat %0d expected %0d %0d", pkt_cnt, beat_cnt, exp_pkts, exp_beats); end
  endtask

`ifdef USR_LP0_PKT_MODE_EN
  task automatic test_pkt_hold();
    m_ready = 1; s_keep = 8'hFF; s_user = 8'h00; s_last = 0;
    for (int k = 0; k < 3; k++) begin
      s_valid = 1; s_data = 64'(300 + k);
      tick();
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL pkt_hold_early%0d: got v%b expected 0", k, m_valid); end
    end
    s_valid = 0;
    for (int w = 0; w < 10; w++) begin
      tick();
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL pkt_hold_wait%0d: got v%b expected 0", w, m_valid); end
    end
    s_valid = 1; s_last = 1; s_data = 64'd303;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL pkt_hold_tlast_cycle: got v%b expected 0", m_valid); end
    tick();
    s_valid = 0; s_last = 0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (m_valid !== 1'b1 || m_data !== 64'(300 + k) || m_last !== (k == 3)) begin errors++; $display("FAIL pkt_hold_out%0d: got v%b d%0d l%b expected v1 d%0d", k, m_valid, m_data, m_last, 300 + k); end
      tick();
    end
    exp_beats += 4; exp_pkts += 1;
    checks++; if (m_valid !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL pkt_hold_end: got v%b level %0d expected 0 0", m_valid, level); end
  endtask

  task automatic test_pkt_escape();
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    m_ready = 1; s_keep = 8'hFF; s_user = 8'h00;
    while (got < 20 && cyc < 200) begin
      s_valid = (sent < 20); s_data = 64'(400 + sent); s_last = (sent == 19);
      #1;
      if (sent < 16) begin
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL pkt_esc_early cyc %0d: got v%b expected 0", cyc, m_valid); end
      end
      if (m_valid === 1'b1) begin
        checks++; if (m_data !== 64'(400 + got) || m_last !== (got == 19)) begin errors++; $display("FAIL pkt_esc_out%0d: got d%0d l%b expected d%0d", got, m_data, m_last, 400 + got); end
        got++;
      end
      if (s_valid && s_ready === 1'b1) sent++;
      tick();
      cyc++;
    end
    s_valid = 0; s_last = 0;
    exp_beats += 20; exp_pkts += 1;
    checks++; if (got !== 20) begin errors++; $display("FAIL pkt_esc_count: got %0d expected 20", got); end
    checks++; if (level !== 5'd0 || pkt_cnt !== exp_pkts) begin errors++; $display("FAIL pkt_esc_end: got level %0d pkt %0d expected 0 %0d", level, pkt_cnt, exp_pkts); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_beats();
`ifdef USR_LP0_PKT_MODE_EN
    test_pkt_hold();
    test_pkt_escape();
`else
    test_fill();
    test_flush();
`endif
    test_counter_wrap();
    test_reset_mid_packet();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got no finish expected finish before 800000");
    $fatal(1, "watchdog");
  end

endmodule
